dlsc_pcie_s6_outbound_arbiter: RTL

Shares the single Spartan-6 PCIe transmit TLP path between two requesters: the outbound write engine (header plus payload) and the outbound read engine (header only).
- Grants whole TLPs using round-robin.
- Registers the selected header.
- Passes the write payload through while counting its beats.
- Sits between the write/read TLP generators and the TX TLP formatter.

---
 rtl/dlsc_pcie_s6_pkg.sv | 23 ++
 rtl/dlsc_rr_arbiter2.sv | 56 +++++
 rtl/dlsc_pcie_s6_outbound_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared types for the Spartan-6 PCIe outbound path: FSM states, grant encoding
// and the TLP length rule (a length field of 0 means 1024 DW).
package dlsc_pcie_s6_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  localparam int LEN_W  = 10;
  localparam int BEAT_W = LEN_W + 1;

  function automatic logic [BEAT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
    return (len == '0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/dlsc_rr_arbiter2.sv
// Two-way round-robin arbiter (write vs read) allowing up to ARB_BURST
// consecutive grants to one requester while the other is also requesting.
module dlsc_rr_arbiter2
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int ARB_BURST = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   req_wr,
  input  logic   req_rd,
  output logic   update,
  output grant_t grant
);

  grant_t     last_grant_reg;
  logic [3:0] burst_cnt_reg;
  logic       primed_reg;
  logic       hold;

  // Until the first grant there is no burst to continue, so the first tie
  // always goes to the opposite of the reset value of last_grant (write).
  always_comb begin
    hold   = primed_reg && ((int'(burst_cnt_reg) + 1) < ARB_BURST);
    update = en && (req_wr || req_rd);
    if (req_wr && req_rd) begin
      if (hold)
        grant = last_grant_reg;
      else
        grant = (last_grant_reg == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
    end else if (req_wr) begin
      grant = GRANT_WRITE;
    end else begin
      grant = GRANT_READ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= GRANT_READ;
      burst_cnt_reg  <= '0;
      primed_reg     <= 1'b0;
    end else if (update) begin
      last_grant_reg <= grant;
      primed_reg     <= 1'b1;
      if (grant == last_grant_reg) begin
        if (burst_cnt_reg != 4'hF)
          burst_cnt_reg <= burst_cnt_reg + 4'd1;
      end else begin
        burst_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/dlsc_pcie_s6_outbound_arbiter.sv
// Shares the Spartan-6 PCIe TX TLP path between the outbound write engine
// (header + payload) and the outbound read engine (header only).
module dlsc_pcie_s6_outbound_arbiter
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int ADDR      = 32,
  parameter int TAGB      = 5,
  parameter int ARB_BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             wr_tlp_h_ready,
  input  logic             wr_tlp_h_valid,
  input  logic [ADDR-3:0]  wr_tlp_h_addr,
  input  logic [9:0]       wr_tlp_h_len,
  input  logic [3:0]       wr_tlp_h_be_first,
  input  logic [3:0]       wr_tlp_h_be_last,
  output logic             wr_tlp_d_ready,
  input  logic             wr_tlp_d_valid,
  input  logic [31:0]      wr_tlp_d_data,
  output logic             rd_tlp_h_ready,
  input  logic             rd_tlp_h_valid,
  input  logic [ADDR-3:0]  rd_tlp_h_addr,
  input  logic [9:0]       rd_tlp_h_len,
  input  logic [3:0]       rd_tlp_h_be_first,
  input  logic [3:0]       rd_tlp_h_be_last,
  input  logic [TAGB-1:0]  rd_tlp_h_tag,
  input  logic             tx_h_ready,
  output logic             tx_h_valid,
  output logic             tx_h_write,
  output logic [ADDR-3:0]  tx_h_addr,
  output logic [9:0]       tx_h_len,
  output logic [3:0]       tx_h_be_first,
  output logic [3:0]       tx_h_be_last,
  output logic [TAGB-1:0]  tx_h_tag,
  input  logic             tx_d_ready,
  output logic             tx_d_valid,
  output logic [31:0]      tx_d_data,
  output logic             tx_d_last,
  input  logic             arb_disable,
  output logic             arb_busy
);

  state_t            state_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic              arb_en;
  logic              arb_update;
  grant_t            arb_grant;
  logic              in_data;
  logic              beat;

  assign arb_en = (state_reg == ST_IDLE) && !arb_disable;

  dlsc_rr_arbiter2 #(
    .ARB_BURST (ARB_BURST)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req_wr (wr_tlp_h_valid),
    .req_rd (rd_tlp_h_valid),
    .update (arb_update),
    .grant  (arb_grant)
  );

  // A grant is only issued toward a valid requester, so ready implies handshake.
  assign wr_tlp_h_ready = arb_update && (arb_grant == GRANT_WRITE);
  assign rd_tlp_h_ready = arb_update && (arb_grant == GRANT_READ);

  assign in_data        = (state_reg == ST_DATA);
  assign tx_d_valid     = in_data && wr_tlp_d_valid;
  assign wr_tlp_d_ready = in_data && tx_d_ready;
  assign tx_d_data      = in_data ? wr_tlp_d_data : '0;
  assign tx_d_last      = in_data && (beat_cnt_reg == 11'd1);
  assign beat           = tx_d_valid && tx_d_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      beat_cnt_reg  <= '0;
      arb_busy      <= 1'b0;
      tx_h_valid    <= 1'b0;
      tx_h_write    <= 1'b0;
      tx_h_addr     <= '0;
      tx_h_len      <= '0;
      tx_h_be_first <= '0;
      tx_h_be_last  <= '0;
      tx_h_tag      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_update) begin
            state_reg  <= ST_HDR;
            arb_busy   <= 1'b1;
            tx_h_valid <= 1'b1;
            if (arb_grant == GRANT_WRITE) begin
              tx_h_write    <= 1'b1;
              tx_h_addr     <= wr_tlp_h_addr;
              tx_h_len      <= wr_tlp_h_len;
              tx_h_be_first <= wr_tlp_h_be_first;
              tx_h_be_last  <= wr_tlp_h_be_last;
              tx_h_tag      <= '0;
            end else begin
              tx_h_write    <= 1'b0;
              tx_h_addr     <= rd_tlp_h_addr;
              tx_h_len      <= rd_tlp_h_len;
              tx_h_be_first <= rd_tlp_h_be_first;
              tx_h_be_last  <= rd_tlp_h_be_last;
              tx_h_tag      <= rd_tlp_h_tag;
            end
          end
        end
        ST_HDR: begin
          if (tx_h_ready) begin
            tx_h_valid <= 1'b0;
            if (tx_h_write) begin
              state_reg    <= ST_DATA;
              beat_cnt_reg <= len_to_beats(tx_h_len);
            end else begin
              state_reg <= ST_IDLE;
              arb_busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg - 11'd1;
            if (tx_d_last) begin
              state_reg <= ST_IDLE;
              arb_busy  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          arb_busy   <= 1'b0;
          tx_h_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
